// File: rtl/pcie_msi_wr_if.sv
// Memory write request bus (address, first-DW data/byte enables, length) with valid/ready handshake.
interface pcie_msi_wr_if #(
    parameter int unsigned ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
    logic [10:0]           len;
    logic                  valid;
    logic                  ready;

    modport master (output addr, data, be, len, valid, input  ready);
    modport slave  (input  addr, data, be, len, valid, output ready);
endinterface

// File: rtl/pcie_msi_rx.sv
// Host-side MSI receiver: claims single-DW writes hitting the MSI address, tracks pending vectors,
// issues them round-robin to the interrupt controller and forwards all other writes through a register stage.
module pcie_msi_rx #(
    parameter int unsigned MSI_COUNT  = 32,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pcie_msi_wr_if.slave          s_wr,
    pcie_msi_wr_if.master         m_wr,
    input  logic                  msi_enable,
    input  logic [ADDR_WIDTH-1:0] msi_addr,
    input  logic [15:0]           msi_data_base,
    input  logic [2:0]            msi_mmenable,
    output logic [4:0]            irq_index,
    output logic                  irq_valid,
    input  logic                  irq_ready,
    output logic [MSI_COUNT-1:0]  irq_pending,
    output logic [15:0]           stat_drop
);
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned DATA_LW = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic                 irq_valid_nxt;
    logic [IDX_W-1:0]     irq_index_nxt;
    logic                 issue_done_c;

    logic                 accept_c;
    logic                 hit_c;
    logic                 msi_ok_c;
    logic                 set_c;
    logic                 drop_c;
    logic                 fwd_c;
    logic [2:0]           mm_c;
    logic [IDX_W-1:0]     mask_c;
    logic [DATA_LW-1:0]   mask16_c;
    logic [IDX_W-1:0]     vector_c;

    logic [MSI_COUNT-1:0] pending_nxt;
    logic [IDX_W-1:0]     sel_idx_c;
    logic [IDX_W-1:0]     hi_idx_c;
    logic [IDX_W-1:0]     lo_idx_c;
    logic                 hi_found_c;

    // Inbound acceptance and MSI classification, using the config present in the accepting cycle
    assign s_wr.ready = !m_wr.valid || m_wr.ready;
    assign accept_c   = s_wr.valid && s_wr.ready;
    assign hit_c      = msi_enable
                        && (s_wr.addr[ADDR_WIDTH-1:2] == msi_addr[ADDR_WIDTH-1:2])
                        && (s_wr.len == LEN_W'(1))
                        && (s_wr.be[1:0] == 2'b11);
    assign mm_c       = (msi_mmenable > 3'd5) ? 3'd5 : msi_mmenable;
    assign mask_c     = IDX_W'((6'd1 << mm_c) - 6'd1);
    assign mask16_c   = {11'd0, mask_c};
    assign vector_c   = s_wr.data[IDX_W-1:0] & mask_c;
    assign msi_ok_c   = ((s_wr.data[DATA_LW-1:0] & ~mask16_c) == (msi_data_base & ~mask16_c))
                        && (32'(vector_c) < MSI_COUNT);
    assign set_c      = accept_c && hit_c && msi_ok_c;
    assign drop_c     = accept_c && hit_c && !msi_ok_c;
    assign fwd_c      = accept_c && !hit_c;

    // Pass-through register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_wr.valid <= 1'b0;
        end else if (fwd_c) begin
            m_wr.valid <= 1'b1;
        end else if (m_wr.ready) begin
            m_wr.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd_c) begin
            m_wr.addr <= s_wr.addr;
            m_wr.data <= s_wr.data;
            m_wr.be   <= s_wr.be;
            m_wr.len  <= s_wr.len;
        end
    end

    // Pending update: a same-cycle set overrides the clear of the vector being retired
    always_comb begin
        pending_nxt = irq_pending;
        for (int i = 0; i < int'(MSI_COUNT); i++) begin
            if (issue_done_c && (irq_index == IDX_W'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (set_c && (vector_c == IDX_W'(i))) begin
                pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_pending <= '0;
            stat_drop   <= '0;
        end else begin
            irq_pending <= pending_nxt;
            if (drop_c && (stat_drop != 16'hFFFF)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end

    // Round-robin pick: lowest set bit at or above ptr, otherwise lowest set bit overall
    always_comb begin
        hi_idx_c   = '0;
        lo_idx_c   = '0;
        hi_found_c = 1'b0;
        for (int i = int'(MSI_COUNT) - 1; i >= 0; i--) begin
            if (irq_pending[i]) begin
                lo_idx_c = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_idx_c   = IDX_W'(i);
                    hi_found_c = 1'b1;
                end
            end
        end
        sel_idx_c = hi_found_c ? hi_idx_c : lo_idx_c;
    end

    // Issue FSM next-state and registered-output values
    always_comb begin
        state_nxt     = state;
        irq_valid_nxt = irq_valid;
        irq_index_nxt = irq_index;
        ptr_nxt       = ptr;
        issue_done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq_pending != '0) begin
                    state_nxt     = ST_ISSUE;
                    irq_valid_nxt = 1'b1;
                    irq_index_nxt = sel_idx_c;
                end
            end
            ST_ISSUE: begin
                if (irq_ready) begin
                    issue_done_c  = 1'b1;
                    irq_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                    ptr_nxt       = (irq_index == IDX_W'(MSI_COUNT - 1)) ? '0 : irq_index + IDX_W'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                irq_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            irq_valid <= 1'b0;
            irq_index <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_nxt;
            irq_valid <= irq_valid_nxt;
            irq_index <= irq_index_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_msi_rx.sv
// Bench for pcie_msi_rx: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pcie_msi_rx;
    localparam int unsigned AW = 64;
    localparam int unsigned NV = 24;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic [10:0]   len;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          msi_enable;
    logic [AW-1:0] msi_addr;
    logic [15:0]   msi_data_base;
    logic [2:0]    msi_mmenable;
    logic [4:0]    irq_index;
    logic          irq_valid;
    logic          irq_ready;
    logic [NV-1:0] irq_pending;
    logic [15:0]   stat_drop;

    pcie_msi_wr_if #(.ADDR_WIDTH(AW)) s_wr ();
    pcie_msi_wr_if #(.ADDR_WIDTH(AW)) m_wr ();

    pcie_msi_rx #(.MSI_COUNT(NV), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .s_wr(s_wr), .m_wr(m_wr),
        .msi_enable(msi_enable), .msi_addr(msi_addr), .msi_data_base(msi_data_base),
        .msi_mmenable(msi_mmenable), .irq_index(irq_index), .irq_valid(irq_valid),
        .irq_ready(irq_ready), .irq_pending(irq_pending), .stat_drop(stat_drop)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   drops_exp = 0;
    bit   rand_mready = 1'b0;
    req_t fwd_q[$];
    req_t exp_fwd[$];
    int   irq_q[$];
    int   exp_order[$];

    // Handshake monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && m_wr.valid && m_wr.ready) fwd_q.push_back({m_wr.addr, m_wr.data, m_wr.be, m_wr.len});
        if (rst_n && irq_valid && irq_ready) irq_q.push_back(int'(irq_index));
    end

    always @(posedge clk) begin
        if (rand_mready) begin
            #1;
            m_wr.ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [10:0] len);
        bit done = 1'b0;
        s_wr.addr  = a;
        s_wr.data  = d;
        s_wr.be    = be;
        s_wr.len   = len;
        s_wr.valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = s_wr.ready;
            step();
        end
        s_wr.valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: request addr=%h not accepted within 200 cycles", a);
        end
    endtask

    task automatic drain_irqs(input int total);
        irq_ready = 1'b1;
        for (int n = 0; n < 400 && irq_q.size() < total; n++) step();
        for (int n = 0; n < 4; n++) step();
        irq_ready = 1'b0;
    endtask

    function automatic void classify(input req_t r, input bit en, input logic [AW-1:0] ma,
                                     input logic [15:0] base, input int unsigned mmc,
                                     output bit hit, output bit ok, output int unsigned vec);
        int unsigned mm;
        int unsigned mask;
        mm   = (mmc > 5) ? 5 : mmc;
        mask = (32'd1 << mm) - 32'd1;
        hit  = en && ((r.addr >> 2) == (ma >> 2)) && (r.len == 11'd1) && (r.be[1:0] == 2'b11);
        vec  = r.data & mask;
        ok   = (({16'd0, r.data[15:0]} & ~mask) == ({16'd0, base} & ~mask)) && (vec < NV);
    endfunction

    task automatic set_cfg_default();
        msi_enable    = 1'b1;
        msi_addr      = 64'hFEE0_0000;
        msi_data_base = 16'h0040;
        msi_mmenable  = 3'd3;
    endtask

    task automatic test_reset();
        set_cfg_default();
        irq_ready  = 1'b0;
        m_wr.ready = 1'b0;
        s_wr.addr  = 64'hFEE0_0000;
        s_wr.data  = 32'h45;
        s_wr.be    = 4'hF;
        s_wr.len   = 11'd1;
        s_wr.valid = 1'b1;
        rst_n      = 1'b0;
        step();
        step();
        checks++;
        if (irq_valid !== 1'b0 || irq_index !== 5'd0) begin
            errors++; $display("FAIL reset_irq: valid=%b index=%0d, required 0/0", irq_valid, irq_index);
        end
        checks++;
        if (irq_pending !== '0 || stat_drop !== 16'd0) begin
            errors++; $display("FAIL reset_state: pending=%h drop=%0d, required 0/0", irq_pending, stat_drop);
        end
        checks++;
        if (m_wr.valid !== 1'b0 || s_wr.ready !== 1'b1) begin
            errors++; $display("FAIL reset_bus: m_valid=%b s_ready=%b, required 0/1", m_wr.valid, s_wr.ready);
        end
        s_wr.valid = 1'b0;
        rst_n      = 1'b1;
        m_wr.ready = 1'b1;
        step();
    endtask

    task automatic test_single();
        irq_q.delete();
        set_cfg_default();
        send(64'hFEE0_0000, 32'h45, 4'hF, 11'd1);
        checks++;
        if (irq_pending !== 24'h20 || irq_valid !== 1'b0) begin
            errors++; $display("FAIL single_pending: pending=%h valid=%b, required 000020/0", irq_pending, irq_valid);
        end
        step();
        checks++;
        if (irq_valid !== 1'b1 || irq_index !== 5'd5) begin
            errors++; $display("FAIL single_issue: valid=%b index=%0d, required 1/5", irq_valid, irq_index);
        end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++;
        if (irq_pending !== '0 || irq_valid !== 1'b0 || irq_q.size() != 1) begin
            errors++; $display("FAIL single_retire: pending=%h valid=%b issues=%0d, required 0/0/1",
                               irq_pending, irq_valid, irq_q.size());
        end
    endtask

    task automatic test_round_robin();
        irq_q.delete();
        irq_ready = 1'b0;
        send(64'hFEE0_0000, 32'h41, 4'hF, 11'd1);
        send(64'hFEE0_0000, 32'h43, 4'hF, 11'd1);
        send(64'hFEE0_0000, 32'h47, 4'hF, 11'd1);
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (irq_valid !== 1'b1 || irq_index !== 5'd1) begin
                errors++; $display("FAIL rr_stall: cycle %0d valid=%b index=%0d, required 1/1", n, irq_valid, irq_index);
            end
            step();
        end
        drain_irqs(3);
        checks++;
        if (irq_q.size() != 3 || irq_q[0] != 1 || irq_q[1] != 3 || irq_q[2] != 7) begin
            errors++; $display("FAIL rr_order: got %p, required 1,3,7", irq_q);
        end
    endtask

    task automatic test_invalid_miss();
        send(64'hFEE0_0000, 32'h85, 4'hF, 11'd1);
        drops_exp++;
        checks++;
        if (stat_drop !== 16'(drops_exp) || irq_pending !== '0) begin
            errors++; $display("FAIL invalid_data: drop=%0d pending=%h, required %0d/0", stat_drop, irq_pending, drops_exp);
        end
        msi_mmenable = 3'd7;
        send(64'hFEE0_0000, 32'h59, 4'hF, 11'd1);
        drops_exp++;
        msi_mmenable = 3'd3;
        checks++;
        if (stat_drop !== 16'(drops_exp) || irq_pending !== '0) begin
            errors++; $display("FAIL invalid_range: drop=%0d pending=%h, required %0d/0", stat_drop, irq_pending, drops_exp);
        end
        fwd_q.delete();
        m_wr.ready = 1'b0;
        send(64'h0000_1000, 32'hDEAD_BEEF, 4'hF, 11'd1);
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (m_wr.valid !== 1'b1 || m_wr.addr !== 64'h1000 || m_wr.data !== 32'hDEAD_BEEF
                || m_wr.be !== 4'hF || m_wr.len !== 11'd1 || s_wr.ready !== 1'b0) begin
                errors++; $display("FAIL miss_hold: cycle %0d valid=%b addr=%h data=%h s_ready=%b", n,
                                   m_wr.valid, m_wr.addr, m_wr.data, s_wr.ready);
            end
            step();
        end
        m_wr.ready = 1'b1;
        step();
        checks++;
        if (m_wr.valid !== 1'b0 || fwd_q.size() != 1) begin
            errors++; $display("FAIL miss_release: valid=%b forwarded=%0d, required 0/1", m_wr.valid, fwd_q.size());
        end
        send(64'hFEE0_0000, 32'h44, 4'hF, 11'd2);
        send(64'hFEE0_0000, 32'h44, 4'hE, 11'd1);
        step();
        checks++;
        if (fwd_q.size() != 3 || irq_pending !== '0 || stat_drop !== 16'(drops_exp)) begin
            errors++; $display("FAIL miss_shape: forwarded=%0d pending=%h drop=%0d, required 3/0/%0d",
                               fwd_q.size(), irq_pending, stat_drop, drops_exp);
        end
    endtask

    task automatic test_coalesce();
        irq_q.delete();
        irq_ready = 1'b0;
        send(64'hFEE0_0000, 32'h42, 4'hF, 11'd1);
        send(64'hFEE0_0000, 32'h42, 4'hF, 11'd1);
        checks++;
        if (irq_pending !== 24'h4) begin
            errors++; $display("FAIL coalesce_pending: pending=%h, required 000004", irq_pending);
        end
        drain_irqs(1);
        checks++;
        if (irq_q.size() != 1 || irq_q[0] != 2 || irq_pending !== '0) begin
            errors++; $display("FAIL coalesce_once: got %p pending=%h, required 2/0", irq_q, irq_pending);
        end
        send(64'hFEE0_0000, 32'h42, 4'hF, 11'd1);
        step();
        s_wr.addr = 64'hFEE0_0000; s_wr.data = 32'h42; s_wr.be = 4'hF; s_wr.len = 11'd1;
        s_wr.valid = 1'b1;
        irq_ready  = 1'b1;
        step();
        s_wr.valid = 1'b0;
        irq_ready  = 1'b0;
        checks++;
        if (irq_pending !== 24'h4 || irq_valid !== 1'b0 || irq_q.size() != 2) begin
            errors++; $display("FAIL race_set_wins: pending=%h valid=%b issues=%0d, required 000004/0/2",
                               irq_pending, irq_valid, irq_q.size());
        end
        drain_irqs(3);
        checks++;
        if (irq_q.size() != 3 || irq_q[2] != 2 || irq_pending !== '0) begin
            errors++; $display("FAIL race_reissue: got %p pending=%h, required 2,2,2/0", irq_q, irq_pending);
        end
    endtask

    task automatic test_disable();
        irq_q.delete();
        fwd_q.delete();
        send(64'hFEE0_0000, 32'h44, 4'hF, 11'd1);
        step();
        msi_enable = 1'b0;
        send(64'hFEE0_0000, 32'h46, 4'hF, 11'd1);
        step();
        checks++;
        if (fwd_q.size() != 1 || fwd_q[0].data !== 32'h46 || irq_pending !== 24'h10
            || irq_valid !== 1'b1 || irq_index !== 5'd4) begin
            errors++; $display("FAIL disable_fwd: forwarded=%0d pending=%h valid=%b index=%0d, required 1/000010/1/4",
                               fwd_q.size(), irq_pending, irq_valid, irq_index);
        end
        msi_enable = 1'b1;
        drain_irqs(1);
        checks++;
        if (irq_q.size() != 1 || irq_q[0] != 4) begin
            errors++; $display("FAIL disable_issue: got %p, required 4", irq_q);
        end
    endtask

    task automatic test_mid_reset();
        send(64'hFEE0_0000, 32'h43, 4'hF, 11'd1);
        m_wr.ready = 1'b0;
        send(64'h0000_2000, 32'h1234_5678, 4'hF, 11'd1);
        checks++;
        if (irq_valid !== 1'b1 || m_wr.valid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: irq_valid=%b m_valid=%b, required 1/1", irq_valid, m_wr.valid);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (irq_valid !== 1'b0 || m_wr.valid !== 1'b0 || irq_pending !== '0 || stat_drop !== 16'd0) begin
            errors++; $display("FAIL midrst_clear: irq_valid=%b m_valid=%b pending=%h drop=%0d, required 0/0/0/0",
                               irq_valid, m_wr.valid, irq_pending, stat_drop);
        end
        rst_n      = 1'b1;
        m_wr.ready = 1'b1;
        drops_exp  = 0;
        step();
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            logic [NV-1:0] bitmap = '0;
            int            first = -1;
            logic [AW-1:0] base_addr;
            irq_q.delete();
            fwd_q.delete();
            exp_fwd.delete();
            exp_order.delete();
            irq_ready   = 1'b0;
            rand_mready = 1'b1;
            base_addr   = {32'($urandom), 32'($urandom)} & ~64'h3;
            for (int n = 0; n < 40; n++) begin
                req_t        r;
                bit          hit;
                bit          ok;
                int unsigned vec;
                int unsigned sel;
                msi_enable    = ($urandom_range(0, 9) != 0);
                msi_addr      = base_addr | 64'(2'($urandom_range(0, 3)));
                msi_data_base = 16'($urandom);
                msi_mmenable  = 3'($urandom_range(0, 7));
                sel = $urandom_range(0, 7);
                if (sel < 6)       r.addr = base_addr | 64'(2'($urandom_range(0, 3)));
                else if (sel == 6) r.addr = {32'($urandom), 32'($urandom)};
                else               r.addr = base_addr ^ (64'd1 << $urandom_range(2, 63));
                r.len  = ($urandom_range(0, 4) != 0) ? 11'd1 : 11'($urandom_range(0, 2047));
                r.be   = ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                r.data = ($urandom_range(0, 9) < 7)
                         ? {16'($urandom), (msi_data_base & 16'hFFE0) | 16'($urandom_range(0, 31))}
                         : 32'($urandom);
                classify(r, msi_enable, msi_addr, msi_data_base, int'(msi_mmenable), hit, ok, vec);
                if (!hit)    exp_fwd.push_back(r);
                else if (ok) begin
                    if (first < 0) first = int'(vec);
                    bitmap[vec] = 1'b1;
                end else drops_exp++;
                send(r.addr, r.data, r.be, r.len);
                if ($urandom_range(0, 3) == 0) step();
            end
            rand_mready = 1'b0;
            step();
            m_wr.ready = 1'b1;
            for (int n = 0; n < 20 && m_wr.valid; n++) step();
            step();
            checks++;
            if (fwd_q.size() != exp_fwd.size()) begin
                errors++; $display("FAIL rand_fwd_count: round %0d got %0d, required %0d", round, fwd_q.size(), exp_fwd.size());
            end else begin
                for (int i = 0; i < exp_fwd.size(); i++) begin
                    checks++;
                    if (fwd_q[i] !== exp_fwd[i]) begin
                        errors++; $display("FAIL rand_fwd_item: round %0d item %0d got %h, required %h",
                                           round, i, fwd_q[i], exp_fwd[i]);
                    end
                end
            end
            checks++;
            if (stat_drop !== 16'(drops_exp) || irq_pending !== bitmap) begin
                errors++; $display("FAIL rand_state: round %0d drop=%0d pending=%h, required %0d/%h",
                                   round, stat_drop, irq_pending, drops_exp, bitmap);
            end
            if (first >= 0) begin
                exp_order.push_back(first);
                for (int k = 1; k < int'(NV); k++) begin
                    int v = (first + k) % int'(NV);
                    if (bitmap[v]) exp_order.push_back(v);
                end
            end
            drain_irqs(exp_order.size());
            checks++;
            if (irq_q != exp_order || irq_pending !== '0) begin
                errors++; $display("FAIL rand_issue_order: round %0d got %p, required %p (pending=%h)",
                                   round, irq_q, exp_order, irq_pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_invalid_miss();
        test_coalesce();
        test_disable();
        test_mid_reset();
        set_cfg_default();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
